// File: rtl/alu_issue.sv
// Two-entry elastic issue stage between decode and the ALU. Operands are resolved at capture
// and kept coherent with the writeback bypass while entries wait in either slot.
`ifndef ALUOP_WIDTH
`define ALUOP_WIDTH 4
`endif
`ifndef ALUOP_ADD
`define ALUOP_ADD 4'd0
`endif

module alu_issue (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [`ALUOP_WIDTH-1:0] i_op,
  input  logic [4:0]              i_rd,
  input  logic [4:0]              i_rs1,
  input  logic [4:0]              i_rs2,
  input  logic [31:0]             i_rs1_val,
  input  logic [31:0]             i_rs2_val,
  input  logic [31:0]             i_imm,
  input  logic [31:0]             i_pc,
  input  logic [1:0]              i_a_sel,
  input  logic [1:0]              i_b_sel,
  input  logic                    i_wb_valid,
  input  logic [4:0]              i_wb_rd,
  input  logic [31:0]             i_wb_data,
  input  logic                    i_flush,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [`ALUOP_WIDTH-1:0] o_op,
  output logic [31:0]             o_a,
  output logic [31:0]             o_b,
  output logic [4:0]              o_rd
);

  typedef struct packed {
    logic [`ALUOP_WIDTH-1:0] op;
    logic [31:0]             a;
    logic [31:0]             b;
    logic [4:0]              rd;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic                    a_rs1;
    logic                    b_rs2;
  } ent_t;

  localparam ent_t RST_ENT = ent_t'{`ALUOP_ADD, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};

  // _p0 is the skid slot, _p1 the output slot
  ent_t ent_p0, ent_p1;
  logic vld_p0, vld_p1, rdy;
  ent_t ent_in, skid_byp, out_byp;
  logic pop, push;

  function automatic logic wb_hit(input logic wbv, input logic [4:0] wbrd, input logic [4:0] rs);
    return wbv && (wbrd != 5'd0) && (wbrd == rs);
  endfunction

  function automatic ent_t held_byp(input ent_t e, input logic wbv, input logic [4:0] wbrd,
                                    input logic [31:0] wbd);
    ent_t r;
    r = e;
    if (e.a_rs1 && wb_hit(wbv, wbrd, e.rs1)) r.a = wbd;
    if (e.b_rs2 && wb_hit(wbv, wbrd, e.rs2)) r.b = wbd;
    return r;
  endfunction

  always_comb begin
    ent_in       = RST_ENT;
    ent_in.op    = i_op;
    ent_in.rd    = i_rd;
    ent_in.rs1   = i_rs1;
    ent_in.rs2   = i_rs2;
    ent_in.a_rs1 = (i_a_sel == 2'd0);
    ent_in.b_rs2 = (i_b_sel == 2'd0);
    case (i_a_sel)
      2'd0:    ent_in.a = wb_hit(i_wb_valid, i_wb_rd, i_rs1) ? i_wb_data : i_rs1_val;
      2'd1:    ent_in.a = i_pc;
      default: ent_in.a = 32'd0;
    endcase
    case (i_b_sel)
      2'd0:    ent_in.b = wb_hit(i_wb_valid, i_wb_rd, i_rs2) ? i_wb_data : i_rs2_val;
      2'd1:    ent_in.b = i_imm;
      2'd2:    ent_in.b = 32'd4;
      default: ent_in.b = 32'd0;
    endcase
  end

  assign skid_byp = held_byp(ent_p0, i_wb_valid, i_wb_rd, i_wb_data);
  assign out_byp  = held_byp(ent_p1, i_wb_valid, i_wb_rd, i_wb_data);
  assign pop      = vld_p1 && i_ready;
  assign push     = i_valid && rdy;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      rdy    <= 1'b1;
      ent_p0 <= RST_ENT;
      ent_p1 <= RST_ENT;
    end else if (i_flush) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      rdy    <= 1'b1;
      ent_p0 <= skid_byp;
      ent_p1 <= out_byp;
    end else if (!vld_p1 || pop) begin
      // A full skid slot implies rdy was low, so no push competes with the refill
      if (vld_p0) begin
        ent_p1 <= skid_byp;
        vld_p1 <= 1'b1;
        vld_p0 <= 1'b0;
        rdy    <= 1'b1;
      end else if (push) begin
        ent_p1 <= ent_in;
        vld_p1 <= 1'b1;
      end else begin
        ent_p1 <= out_byp;
        vld_p1 <= 1'b0;
      end
    end else begin
      ent_p1 <= out_byp;
      if (push) begin
        ent_p0 <= ent_in;
        vld_p0 <= 1'b1;
        rdy    <= 1'b0;
      end else begin
        ent_p0 <= skid_byp;
      end
    end
  end

  assign o_valid = vld_p1;
  assign o_ready = rdy;
  assign o_op    = ent_p1.op;
  assign o_a     = ent_p1.a;
  assign o_b     = ent_p1.b;
  assign o_rd    = ent_p1.rd;

endmodule

// File: tb/tb_alu_issue.sv
// Directed and short random bench for alu_issue with a queue scoreboard of resolved operands.
`ifndef ALUOP_WIDTH
`define ALUOP_WIDTH 4
`endif
`ifndef ALUOP_ADD
`define ALUOP_ADD 4'd0
`endif

module tb_alu_issue;
  logic                    clk = 1'b0;
  logic                    i_rst, i_valid, o_ready, i_wb_valid, i_flush, o_valid, i_ready;
  logic [`ALUOP_WIDTH-1:0] i_op, o_op;
  logic [4:0]              i_rd, i_rs1, i_rs2, i_wb_rd, o_rd;
  logic [31:0]             i_rs1_val, i_rs2_val, i_imm, i_pc, i_wb_data, o_a, o_b;
  logic [1:0]              i_a_sel, i_b_sel;

  always #5 clk = ~clk;

  alu_issue dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
    .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rs1_val(i_rs1_val), .i_rs2_val(i_rs2_val),
    .i_imm(i_imm), .i_pc(i_pc), .i_a_sel(i_a_sel), .i_b_sel(i_b_sel),
    .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data), .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_op(o_op), .o_a(o_a), .o_b(o_b), .o_rd(o_rd)
  );

  typedef struct {
    logic [`ALUOP_WIDTH-1:0] op;
    logic [31:0]             a, b;
    logic [4:0]              rd, rs1, rs2;
    logic                    fa, fb;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic hit(input logic [4:0] rs);
    return i_wb_valid && (i_wb_rd != 5'd0) && (i_wb_rd == rs);
  endfunction

  function automatic exp_t model_cap();
    exp_t e;
    e.op = i_op; e.rd = i_rd; e.rs1 = i_rs1; e.rs2 = i_rs2;
    e.fa = (i_a_sel == 2'd0);
    e.fb = (i_b_sel == 2'd0);
    if (i_a_sel == 2'd0)      e.a = hit(i_rs1) ? i_wb_data : i_rs1_val;
    else if (i_a_sel == 2'd1) e.a = i_pc;
    else                      e.a = 32'd0;
    if (i_b_sel == 2'd0)      e.b = hit(i_rs2) ? i_wb_data : i_rs2_val;
    else if (i_b_sel == 2'd1) e.b = i_imm;
    else if (i_b_sel == 2'd2) e.b = 32'd4;
    else                      e.b = 32'd0;
    return e;
  endfunction

  // One clock: score the departing entry before the edge, update the model after it.
  task automatic tick();
    logic do_pop, do_push;
    exp_t e, n;
    @(negedge clk);
    do_pop  = o_valid && i_ready && !i_rst && !i_flush;
    do_push = i_valid && o_ready && !i_rst && !i_flush;
    n = model_cap();
    if (do_pop) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pop observed rd=%0d expected no entry", o_rd);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_op", 32'(o_op), 32'(e.op));
        chk("sb_a", o_a, e.a);
        chk("sb_b", o_b, e.b);
        chk("sb_rd", 32'(o_rd), 32'(e.rd));
      end
    end
    @(posedge clk);
    #1;
    if (i_rst || i_flush) sb.delete();
    else begin
      foreach (sb[i]) begin
        if (sb[i].fa && hit(sb[i].rs1)) sb[i].a = i_wb_data;
        if (sb[i].fb && hit(sb[i].rs2)) sb[i].b = i_wb_data;
      end
      if (do_push) sb.push_back(n);
    end
  endtask

  task automatic offer(input logic [`ALUOP_WIDTH-1:0] op, input logic [4:0] rd, rs1, rs2,
                       input logic [31:0] r1v, r2v, imm, pc, input logic [1:0] as, bs);
    i_valid = 1'b1; i_op = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2;
    i_rs1_val = r1v; i_rs2_val = r2v; i_imm = imm; i_pc = pc; i_a_sel = as; i_b_sel = bs;
  endtask

  task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
    i_wb_valid = v; i_wb_rd = rd; i_wb_data = d;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_o_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_o_ready"}, 32'(o_ready), 32'd1);
    chk({tag, "_o_op"}, 32'(o_op), 32'(`ALUOP_ADD));
    chk({tag, "_o_a"}, o_a, 32'd0);
    chk({tag, "_o_b"}, o_b, 32'd0);
    chk({tag, "_o_rd"}, 32'(o_rd), 32'd0);
  endtask

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_ready = 1'b1; i_valid = 1'b0;
    i_op = '0; i_rd = '0; i_rs1 = '0; i_rs2 = '0; i_rs1_val = '0; i_rs2_val = '0;
    i_imm = '0; i_pc = '0; i_a_sel = '0; i_b_sel = '0;
    wb(1'b0, 5'd0, 32'd0);
    tick();
    tick();
    i_rst = 1'b0;
    chk_reset_vals("reset");
    tick();
    chk("post_reset_idle", 32'(o_valid), 32'd0);

    // Operand select: pc and constant 4
    offer(`ALUOP_ADD, 5'd3, 5'd1, 5'd2, 32'h77, 32'h88, 32'h0, 32'h100, 2'd1, 2'd2);
    tick();
    chk("opsel_valid", 32'(o_valid), 32'd1);
    chk("opsel_a", o_a, 32'h100);
    chk("opsel_b", o_b, 32'd4);

    // Capture bypass, then x0 must not bypass; back to back with no bubble
    offer(4'd1, 5'd4, 5'd5, 5'd0, 32'h11, 32'h0, 32'h0, 32'h0, 2'd0, 2'd3);
    wb(1'b1, 5'd5, 32'hAA);
    tick();
    chk("cap_byp_a", o_a, 32'hAA);
    offer(4'd2, 5'd6, 5'd0, 5'd0, 32'h11, 32'h0, 32'h0, 32'h0, 2'd0, 2'd3);
    wb(1'b1, 5'd0, 32'hAA);
    tick();
    chk("x0_no_byp_a", o_a, 32'h11);
    chk("no_bubble_rd", 32'(o_rd), 32'd6);
    wb(1'b0, 5'd0, 32'd0);
    i_valid = 1'b0;
    tick();
    chk("drained_valid", 32'(o_valid), 32'd0);

    // Stall into the skid slot, ignored offer while full, then drain in order
    i_ready = 1'b0;
    offer(4'd3, 5'd10, 5'd0, 5'd0, 32'h0, 32'h0, 32'h10, 32'h0, 2'd2, 2'd1);
    tick();
    chk("stall_e1_ready", 32'(o_ready), 32'd1);
    offer(4'd4, 5'd11, 5'd0, 5'd0, 32'h0, 32'h0, 32'h20, 32'h0, 2'd2, 2'd1);
    tick();
    chk("stall_e2_ready", 32'(o_ready), 32'd0);
    chk("stall_hold_rd", 32'(o_rd), 32'd10);
    offer(4'd5, 5'd12, 5'd0, 5'd0, 32'h0, 32'h0, 32'h30, 32'h0, 2'd2, 2'd1);
    tick();
    chk("full_ignore_rd", 32'(o_rd), 32'd10);
    chk("full_ignore_ready", 32'(o_ready), 32'd0);
    i_valid = 1'b0; i_ready = 1'b1;
    tick();
    chk("skid_move_valid", 32'(o_valid), 32'd1);
    chk("skid_move_rd", 32'(o_rd), 32'd11);
    chk("skid_move_ready", 32'(o_ready), 32'd1);
    tick();
    chk("skid_drained", 32'(o_valid), 32'd0);

    // Held bypass on a stalled OUT entry, and none when B came from imm
    i_ready = 1'b0;
    offer(4'd5, 5'd13, 5'd0, 5'd7, 32'h0, 32'h1234, 32'h0, 32'h0, 2'd2, 2'd0);
    tick();
    i_valid = 1'b0;
    wb(1'b1, 5'd7, 32'hDEAD);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    chk("held_byp_b", o_b, 32'hDEAD);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    offer(4'd6, 5'd14, 5'd0, 5'd7, 32'h0, 32'h1234, 32'h55, 32'h0, 2'd2, 2'd1);
    tick();
    i_valid = 1'b0;
    wb(1'b1, 5'd7, 32'hDEAD);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    chk("held_imm_b", o_b, 32'h55);
    // Bypass applied to the entry moving from SKID to OUT
    offer(4'd7, 5'd15, 5'd9, 5'd0, 32'h1, 32'h0, 32'h0, 32'h0, 2'd0, 2'd3);
    tick();
    chk("skid_fill_ready", 32'(o_ready), 32'd0);
    i_valid = 1'b0; i_ready = 1'b1;
    wb(1'b1, 5'd9, 32'hBEEF);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    chk("move_byp_a", o_a, 32'hBEEF);
    chk("move_byp_rd", 32'(o_rd), 32'd15);
    tick();

    // Flush with both slots full and an entry offered
    i_ready = 1'b0;
    offer(4'd1, 5'd16, 5'd0, 5'd0, 32'h0, 32'h0, 32'h1, 32'h0, 2'd2, 2'd1);
    tick();
    offer(4'd1, 5'd17, 5'd0, 5'd0, 32'h0, 32'h0, 32'h2, 32'h0, 2'd2, 2'd1);
    tick();
    offer(4'd1, 5'd18, 5'd0, 5'd0, 32'h0, 32'h0, 32'h3, 32'h0, 2'd2, 2'd1);
    i_flush = 1'b1;
    tick();
    chk("flush_valid", 32'(o_valid), 32'd0);
    chk("flush_ready", 32'(o_ready), 32'd1);
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    tick();
    chk("flush_lost", 32'(o_valid), 32'd0);
    // Flush while o_ready is high: the offered entry must still be dropped
    i_ready = 1'b0;
    offer(4'd2, 5'd19, 5'd0, 5'd0, 32'h0, 32'h0, 32'h4, 32'h0, 2'd2, 2'd1);
    tick();
    offer(4'd2, 5'd20, 5'd0, 5'd0, 32'h0, 32'h0, 32'h5, 32'h0, 2'd2, 2'd1);
    i_flush = 1'b1;
    tick();
    chk("flush2_valid", 32'(o_valid), 32'd0);
    chk("flush2_ready", 32'(o_ready), 32'd1);
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    tick();
    chk("flush2_lost", 32'(o_valid), 32'd0);

    // Reset together with flush while both slots are full
    i_ready = 1'b0;
    offer(4'd3, 5'd21, 5'd0, 5'd0, 32'h0, 32'h0, 32'h6, 32'h0, 2'd2, 2'd1);
    tick();
    offer(4'd3, 5'd22, 5'd0, 5'd0, 32'h0, 32'h0, 32'h7, 32'h0, 2'd2, 2'd1);
    tick();
    offer(4'd3, 5'd23, 5'd0, 5'd0, 32'h0, 32'h0, 32'h8, 32'h0, 2'd2, 2'd1);
    i_rst = 1'b1; i_flush = 1'b1;
    tick();
    chk_reset_vals("rst_flush");
    i_rst = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    tick();
    chk("rst_nothing_emerges", 32'(o_valid), 32'd0);

    // Random traffic with random writebacks
    for (int k = 0; k < 60; k++) begin
      offer(`ALUOP_WIDTH'($urandom), 5'($urandom), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom,
            2'($urandom), 2'($urandom));
      i_valid = 1'($urandom);
      i_ready = 1'($urandom);
      wb(1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      tick();
    end
    i_valid = 1'b0; i_ready = 1'b1;
    wb(1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 8 && sb.size() != 0; k++) tick();
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("drain_valid", 32'(o_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
